// File: rtl/sync_word_sender.sv
// Transmit-side source for the sync-word link: buffers upstream words in a small FIFO
// and emits each one with a single-cycle strobe, holding the word across the receiver's capture edge.
module sync_word_sender #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          GlobalReset,
  input  logic [31:0]   data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [31:0]   sync_o,
  output logic          srdyo,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_GAPW  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [GW-1:0] r_gap;
  logic [31:0]   r_sync;
  logic          r_srdy;
  logic          r_ovf;

  logic          w_push;
  logic          w_load;
  logic          w_nonempty;
  logic [1:0]    w_state_nxt;
  logic [GW-1:0] w_gap_nxt;

  // ready is combinational from the registered count, so a push never lands in a full FIFO
  assign ready_o    = (r_count < CW'(DEPTH));
  assign w_push     = valid_i & ready_o;
  assign w_nonempty = (r_count != '0);

  assign sync_o     = r_sync;
  assign srdyo      = r_srdy;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;

  // Pacing FSM: a load edge pulses the strobe, then GAP low cycles before the next load.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_gap_nxt   = GW'(GAP - 1);
        w_state_nxt = (GAP == 1) ? S_READY : S_GAPW;
      end
      S_GAPW: begin
        w_gap_nxt = r_gap - GW'(1);
        if (r_gap <= GW'(1)) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (w_nonempty) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_sync  <= '0;
      r_srdy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_srdy  <= w_load;
      if (w_load) begin
        r_sync <= r_mem[r_rptr];
      end
    end
  end

  // FIFO storage carries no reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push && !GlobalReset) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_load) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (valid_i && !ready_o) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_word_sender.sv
// Self-checking bench for sync_word_sender: GAP=1 and GAP=3 instances, a receive-stage
// model feeding a scoreboard, and per-cycle strobe/occupancy checks.
module tb_sync_word_sender;

  logic        clk;
  logic        rst;
  logic [31:0] din_a, din_b;
  logic        vld_a, vld_b;
  logic        rdy_a, rdy_b;
  logic [31:0] sync_a, sync_b;
  logic        srdy_a, srdy_b;
  logic [2:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];
  logic        rx_pend;
  logic        prev_a, prev_b;
  int          consec_err;

  sync_word_sender #(.DEPTH(4), .GAP(1), .CW(3)) u_dut_a (
    .clk(clk), .GlobalReset(rst), .data_i(din_a), .valid_i(vld_a), .ready_o(rdy_a),
    .sync_o(sync_a), .srdyo(srdy_a), .count_o(cnt_a), .overflow_o(ovf_a)
  );

  sync_word_sender #(.DEPTH(4), .GAP(3), .CW(3)) u_dut_b (
    .clk(clk), .GlobalReset(rst), .data_i(din_b), .valid_i(vld_b), .ready_o(rdy_b),
    .sync_o(sync_b), .srdyo(srdy_b), .count_o(cnt_b), .overflow_o(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive stage: samples the strobe on one edge, captures the word on the next
  always @(posedge clk) begin
    if (rst) begin
      rx_pend <= 1'b0;
    end else begin
      if (rx_pend) cap_q.push_back(sync_a);
      rx_pend <= srdy_a;
    end
  end

  initial begin
    consec_err = 0;
    prev_a     = 1'b0;
    prev_b     = 1'b0;
  end

  always @(negedge clk) begin
    if ((srdy_a && prev_a) || (srdy_b && prev_b)) consec_err++;
    prev_a <= srdy_a;
    prev_b <= srdy_b;
  end

  task automatic test_reset();
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sync_a !== 32'h0) begin n_err++; $display("FAIL reset_sync got %h want 0", sync_a); end
    n_cmp++; if (srdy_a !== 1'b0)  begin n_err++; $display("FAIL reset_srdy got %b want 0", srdy_a); end
    n_cmp++; if (cnt_a !== 3'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", cnt_a); end
    n_cmp++; if (rdy_a !== 1'b1)   begin n_err++; $display("FAIL reset_ready got %b want 1", rdy_a); end
    n_cmp++; if (ovf_a !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
    n_cmp++; if ({srdy_b, cnt_b, rdy_b, ovf_b} !== 6'b0_000_1_0) begin
      n_err++; $display("FAIL reset_b got %b want 000010", {srdy_b, cnt_b, rdy_b, ovf_b});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (srdy_a !== 1'b0)  begin n_err++; $display("FAIL post_reset_srdy got %b want 0", srdy_a); end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_single();
    logic [31:0] e, c;
    @(negedge clk); din_a = 32'hDEADBEEF; vld_a = 1'b1; exp_q.push_back(32'hDEADBEEF);
    @(negedge clk); vld_a = 1'b0;
    n_cmp++; if (cnt_a !== 3'd1) begin n_err++; $display("FAIL single_cnt1 got %0d want 1", cnt_a); end
    n_cmp++; if (srdy_a !== 1'b0) begin n_err++; $display("FAIL single_srdy0 got %b want 0", srdy_a); end
    @(negedge clk);
    n_cmp++; if (srdy_a !== 1'b1) begin n_err++; $display("FAIL single_srdy1 got %b want 1", srdy_a); end
    n_cmp++; if (sync_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_sync got %h want deadbeef", sync_a); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL single_cnt0 got %0d want 0", cnt_a); end
    @(negedge clk);
    n_cmp++; if (srdy_a !== 1'b0) begin n_err++; $display("FAIL single_srdy_drop got %b want 0", srdy_a); end
    n_cmp++; if (sync_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold got %h want deadbeef", sync_a); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL single_ovf got %b want 0", ovf_a); end
    for (int t = 0; t < 64 && cap_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_cmp++; if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_ncap got %0d want %0d", cap_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); c = cap_q.pop_front();
      n_cmp++; if (c !== e) begin n_err++; $display("FAIL single_word got %h want %h", c, e); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_burst();
    logic [31:0] e, c;
    int j;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        j = k - 1;
        n_cmp++; if (srdy_a !== (j == 1 || j == 3 || j == 5 || j == 7)) begin
          n_err++; $display("FAIL burst_srdy[%0d] got %b", j, srdy_a);
        end
        if (j == 1 || j == 3 || j == 5 || j == 7) begin
          n_cmp++; if (sync_a !== 32'((j + 1) / 2)) begin
            n_err++; $display("FAIL burst_sync[%0d] got %h want %h", j, sync_a, 32'((j + 1) / 2));
          end
        end
      end
      vld_a = (k < 4);
      din_a = 32'(k + 1);
      if (k < 4) exp_q.push_back(32'(k + 1));
    end
    vld_a = 1'b0;
    for (int t = 0; t < 64 && cap_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_cmp++; if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL burst_ncap got %0d want %0d", cap_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); c = cap_q.pop_front();
      n_cmp++; if (c !== e) begin n_err++; $display("FAIL burst_word got %h want %h", c, e); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] e, c;
    int j;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        j = k - 1;
        if (j == 5) begin
          n_cmp++; if ({rdy_a, cnt_a} !== {1'b1, 3'd3}) begin
            n_err++; $display("FAIL ovf_j5 got rdy=%b cnt=%0d want rdy=1 cnt=3", rdy_a, cnt_a);
          end
        end
        if (j == 6) begin
          n_cmp++; if ({rdy_a, cnt_a, ovf_a} !== {1'b0, 3'd4, 1'b0}) begin
            n_err++; $display("FAIL ovf_full got rdy=%b cnt=%0d ovf=%b want 0/4/0", rdy_a, cnt_a, ovf_a);
          end
        end
        if (j == 7) begin
          n_cmp++; if ({rdy_a, cnt_a, ovf_a} !== {1'b1, 3'd3, 1'b1}) begin
            n_err++; $display("FAIL ovf_set got rdy=%b cnt=%0d ovf=%b want 1/3/1", rdy_a, cnt_a, ovf_a);
          end
        end
      end
      vld_a = (k < 8);
      din_a = 32'h10 + 32'(k);
      if (k < 7) exp_q.push_back(32'h10 + 32'(k));
    end
    vld_a = 1'b0;
    for (int t = 0; t < 64 && cap_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf_a); end
    n_cmp++; if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ovf_ncap got %0d want %0d", cap_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); c = cap_q.pop_front();
      n_cmp++; if (c !== e) begin n_err++; $display("FAIL ovf_word got %h want %h", c, e); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  // Second word of each pair is pushed on the very edge the first one loads
  task automatic test_push_on_load();
    logic [31:0] e, c;
    int j;
    int widx;
    widx = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 20) begin
        j = k - 1;
        n_cmp++; if (srdy_a !== (j % 2 == 1)) begin
          n_err++; $display("FAIL pol_srdy[%0d] got %b want %b", j, srdy_a, (j % 2 == 1));
        end
        n_cmp++; if (cnt_a !== ((j % 4 == 3) ? 3'd0 : 3'd1)) begin
          n_err++; $display("FAIL pol_cnt[%0d] got %0d", j, cnt_a);
        end
        if (j % 2 == 1) begin
          n_cmp++; if (sync_a !== 32'hA0 + 32'((j - 1) / 2)) begin
            n_err++; $display("FAIL pol_sync[%0d] got %h want %h", j, sync_a, 32'hA0 + 32'((j - 1) / 2));
          end
        end
      end
      vld_a = (k < 20) && ((k % 4) < 2);
      din_a = 32'hA0 + 32'(widx);
      if (vld_a) begin
        exp_q.push_back(din_a);
        widx++;
      end
    end
    vld_a = 1'b0;
    for (int t = 0; t < 64 && cap_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_cmp++; if (cap_q.size() != 10) begin n_err++; $display("FAIL pol_ncap got %0d want 10", cap_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); c = cap_q.pop_front();
      n_cmp++; if (c !== e) begin n_err++; $display("FAIL pol_word got %h want %h", c, e); end
    end
    n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL pol_ovf_sticky got %b want 1", ovf_a); end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_gap3();
    logic [31:0] wb[3];
    logic [31:0] want;
    int j;
    for (int i = 0; i < 3; i++) wb[i] = 32'hC0DE0000 + 32'(i);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        j = k - 1;
        n_cmp++; if (srdy_b !== (j == 1 || j == 5 || j == 9)) begin
          n_err++; $display("FAIL gap3_srdy[%0d] got %b", j, srdy_b);
        end
        want = (j >= 9) ? wb[2] : (j >= 5) ? wb[1] : (j >= 1) ? wb[0] : 32'h0;
        n_cmp++; if (sync_b !== want) begin
          n_err++; $display("FAIL gap3_sync[%0d] got %h want %h", j, sync_b, want);
        end
        if (j == 2) begin
          n_cmp++; if (cnt_b !== 3'd2) begin n_err++; $display("FAIL gap3_cnt got %0d want 2", cnt_b); end
        end
      end
      vld_b = (k < 3);
      din_b = (k < 3) ? wb[k] : 32'h0;
    end
    vld_b = 1'b0;
    n_cmp++; if (cnt_b !== 3'd0) begin n_err++; $display("FAIL gap3_drain got %0d want 0", cnt_b); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        n_cmp++; if ({srdy_a, cnt_a} !== {1'b1, 3'd2}) begin
          n_err++; $display("FAIL rmid_pre got srdy=%b cnt=%0d want 1/2", srdy_a, cnt_a);
        end
        n_cmp++; if (sync_a !== 32'h2) begin n_err++; $display("FAIL rmid_pre_sync got %h want 2", sync_a); end
      end
      vld_a = (k < 4);
      din_a = 32'(k + 1);
      rst   = (k == 4);
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (srdy_a !== 1'b0)  begin n_err++; $display("FAIL rmid_srdy got %b want 0", srdy_a); end
    n_cmp++; if (sync_a !== 32'h0) begin n_err++; $display("FAIL rmid_sync got %h want 0", sync_a); end
    n_cmp++; if (cnt_a !== 3'd0)   begin n_err++; $display("FAIL rmid_cnt got %0d want 0", cnt_a); end
    n_cmp++; if (rdy_a !== 1'b1)   begin n_err++; $display("FAIL rmid_rdy got %b want 1", rdy_a); end
    n_cmp++; if (ovf_a !== 1'b0)   begin n_err++; $display("FAIL rmid_ovf got %b want 0", ovf_a); end
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (srdy_a) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rmid_no_pulse got %0d want 0", pulses); end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_strobe_rules();
    n_cmp++; if (consec_err != 0) begin
      n_err++; $display("FAIL strobe_consecutive got %0d want 0", consec_err);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
    test_reset();
    test_single();
    repeat (4) @(negedge clk);
    test_burst();
    repeat (4) @(negedge clk);
    test_overflow();
    repeat (4) @(negedge clk);
    test_push_on_load();
    repeat (4) @(negedge clk);
    test_gap3();
    repeat (4) @(negedge clk);
    test_reset_mid();
    test_strobe_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_word_sender.md
Name: sync_word_sender

Overview:
- Transmit-side source for the sync-word link.
- Accepts 32-bit words from an upstream producer through a valid/ready interface and buffers them in a small FIFO.
- Emits each word on sync_o with a one-cycle srdyo pulse, paced to suit the link's receive stage. That stage samples srdyo on one edge and captures sync_o on the following edge.
- It sits in front of the sync delay/receive stage and guarantees the data is stable across both of those edges.

Parameters:
- DEPTH, 4: FIFO depth in words. Must be a power of two, minimum 2.
- GAP, 1: number of cycles srdyo is held low after each pulse before the next pulse may start. Minimum 1.
- CW, 3: width of count_o. Must equal clog2(DEPTH)+1.

Ports:
- clk  input  1  : single clock; all logic is on the rising edge.
- GlobalReset  input  1  : synchronous, active-high reset.
- data_i  input  32  : upstream word.
- valid_i  input  1  : upstream word valid.
- ready_o  output  1  : FIFO can accept a word. Equals (count < DEPTH).
- sync_o  output  32  : registered word to the link.
- srdyo  output  1  : registered one-cycle strobe marking a new word on sync_o.
- count_o  output  CW  : current FIFO occupancy.
- overflow_o  output  1  : sticky flag. Set when valid_i is high while ready_o is low.

Behaviour:
- Reset (GlobalReset=1 at a rising edge):
  - sync_o=0, srdyo=0, overflow_o=0.
  - FIFO pointers=0, count_o=0, so ready_o=1.
  - State=IDLE, gap counter=0.
  - Reset mid-transfer abandons the in-flight word and all buffered words. No pulse is issued on the cycle after reset.
- Push:
  - On an edge with valid_i=1 and ready_o=1, data_i is written at the write pointer.
  - The write pointer wraps modulo DEPTH.
- Overflow:
  - valid_i=1 with ready_o=0 drops the word and sets overflow_o.
  - overflow_o clears only on reset.
- Pop: occurs only on a load edge (see the state machine). It reads the head entry; the read pointer wraps modulo DEPTH.
- Occupancy: count_o increments on a push, decrements on a pop, and is unchanged on a simultaneous push and pop. A push into a full FIFO is impossible because ready_o is combinational from the registered count.
- No bypass: a word pushed at edge E is eligible to load no earlier than edge E+1.
- State machine, decided at each edge from the registered count and the current state:
  - IDLE: if count>0, it is a load edge. sync_o<=head, pop, srdyo<=1, go to SEND. Otherwise srdyo stays 0.
  - SEND: srdyo<=0, gap counter<=GAP-1. If GAP=1, go to READY; otherwise go to GAPW.
  - GAPW: decrement the gap counter. When it reaches 1, go to READY.
  - READY: if count>0, it is a load edge, handled exactly as in IDLE (go to SEND). Otherwise go to IDLE.
- sync_o timing:
  - sync_o changes only on load edges.
  - It is held for at least GAP+1 cycles after each srdyo rise, so the receiver's capture edge always sees the pulsed word.
- Throughput and latency:
  - With GAP=1, back-to-back words give srdyo=1,0,1,0,...: one word per 2 cycles.
  - In general the pulse period is GAP+1 cycles.
  - Latency from the accept edge into an empty, IDLE block to srdyo high is 1 cycle.
- Simultaneous push and load when count=DEPTH: ready_o=0 that cycle, so there is no push. ready_o returns to 1 on the cycle after the pop.
- Push in the same cycle the FIFO goes empty: the pushed word is loaded at the next READY/IDLE evaluation. It is never lost or duplicated.
- srdyo is never high on two consecutive cycles. srdyo is never high with an empty load.

Test Plan:
- Reset, then push 0xDEADBEEF on a single cycle -> next cycle sync_o=0xDEADBEEF and srdyo=1 for exactly one cycle. sync_o is held ≥2 cycles, count_o goes 1->0, overflow_o=0.
- Burst of 4 valid pushes 0x1..0x4 on consecutive cycles, GAP=1 -> srdyo pattern 1,0,1,0,1,0,1,0. sync_o steps 1,2,3,4 on the pulse cycles. A model of the receive stage (sample strobe, capture next edge) captures 1,2,3,4 in order.
- Hold valid_i high for 8 consecutive cycles with data 0x10..0x17 -> ready_o drops when count_o=4 and overflow_o sets. Exactly the accepted words appear on sync_o in order; the dropped words never appear.
- GAP=3 build, 3 queued words -> srdyo high every 4th cycle only. sync_o stable for 4 cycles per word.
- Assert GlobalReset for 1 cycle while in SEND with 2 words queued -> next cycle srdyo=0, sync_o=0, count_o=0, ready_o=1, overflow_o=0. No further pulses until a new push.
- Push at the exact cycle the last word loads (count 1->1 net) -> the new word pulses at the next legal slot. No duplicate pulse or skipped word occurs, and pointers wrap correctly after 2*DEPTH total words.
